// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART TX arbiter block:
//                FSM state encoding, requester IDs, data width, parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Requester identifiers; also used as grant values and ready indices
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_KBD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity bit: XOR of all data bits
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_arbiter2.sv
// ============================================================================
//  Module      : uart_rr_arbiter2
//  Description : Two-way round-robin winner selection with one-hot ready.
//                A tie goes to the requester that did not own the last frame.
//                Purely combinational; enable gates all readies.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_arbiter2
    import uart_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       enable_i,
    output logic [1:0] ready_o,
    output logic       winner_o,
    output logic       req_o
);

    // Winner selection and one-hot ready generation
    always_comb begin
        winner_o = REQ_CPU;
        if (valid_i == 2'b11) begin
            winner_o = ~last_i;
        end else if (valid_i[REQ_KBD]) begin
            winner_o = REQ_KBD;
        end
        req_o   = enable_i & (|valid_i);
        ready_o = 2'b00;
        if (req_o) begin
            ready_o[winner_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one 8N1 UART transmitter between a CPU byte source and
//                a keyboard scan-code source with round-robin arbitration at
//                frame boundaries. Optional even parity bit (8E1) when the
//                macro UART_TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] cpu_data_i,
    input  logic                   cpu_valid_i,
    output logic                   cpu_ready_o,
    input  logic [UART_DATA_W-1:0] kbd_data_i,
    input  logic                   kbd_valid_i,
    output logic                   kbd_ready_o,
    output logic                   uart_tx,
    output logic                   busy_o,
    output logic                   grant_o
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             idx_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   tx_q;
    logic                   grant_q;
`ifdef UART_TX_PARITY_EN
    logic                   par_q;
`endif

    logic [1:0]             w_ready;
    logic                   w_winner;
    logic                   w_req;
    logic                   w_enable;
    logic                   w_bit_end;
    logic [UART_DATA_W-1:0] w_byte;

    // Readies stay low while reset is held so no byte is handed over and lost
    assign w_enable  = (state_q == ST_IDLE) && !rst;
    assign w_bit_end = (cnt_q == BIT_LAST);
    assign w_byte    = (w_winner == REQ_KBD) ? kbd_data_i : cpu_data_i;

    uart_rr_arbiter2 u_arb (
        .valid_i  ({kbd_valid_i, cpu_valid_i}),
        .last_i   (grant_q),
        .enable_i (w_enable),
        .ready_o  (w_ready),
        .winner_o (w_winner),
        .req_o    (w_req)
    );

    // Frame FSM: baud counter, bit index, shifter and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            grant_q <= REQ_KBD;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (w_req) begin
                        shift_q <= w_byte;
                        grant_q <= w_winner;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
`ifdef UART_TX_PARITY_EN
                        par_q   <= even_parity(w_byte);
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready_o = w_ready[REQ_CPU];
    assign kbd_ready_o = w_ready[REQ_KBD];
    assign uart_tx     = tx_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = grant_q;

endmodule

`default_nettype wire
